pulse_window_ctrl: RTL and testbench
====================================

# pulse_window_ctrl

Sequencing controller for the zero-point pulse analyzer.
- Opens measurement windows of a programmable number of accepted samples, gating the analyzer's `valid_in`.
- Applies threshold updates only at window boundaries.
- Clears analyzer pending-pair state between windows.
- Drains the analyzer pipeline and accumulates its per-cycle `pulse_count` into a per-window total, delivered over a valid/ready result port.
- Sits between the sample front-end/register file and the analyzer.

## Interface
Parameters:
- DATA_WIDTH, 20, threshold width (Q16.4, signed)
- CNT_W, 24, result pulse-total width
- LEN_W, 32, window length / sample counter width
- PIPE_LAT, 8, analyzer `valid_in`→`valid_out` latency in cycles

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- start  in  1  begin window (sampled in IDLE only)
- stop  in  1  end current window early / cancel continuous mode
- cont_mode  in  1  auto re-arm after each result handshake
- win_len  in  LEN_W  accepted samples per window; 0 treated as 1
- cfg_wr  in  1  load threshold shadows
- diff_th_in, abs_th_in  in  DATA_WIDTH each  threshold shadow data
- samp_valid  in  1  upstream sample beat
- ana_valid_in  out  1  gated beat to analyzer
- ana_rst_n  out  1  analyzer clear (registered)
- ana_diff_th, ana_abs_th  out  DATA_WIDTH each  applied thresholds
- ana_pulse_count  in  5  analyzer count
- ana_valid_out  in  1  analyzer output valid
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_count  out  CNT_W  window pulse total
- res_samples  out  LEN_W  samples accepted in window
- res_sat  out  1  res_count saturated
- res_peak  out  5  max single-cycle pulse_count (macro-dependent)
- busy  out  1  state != IDLE

## Operation
- States: IDLE → ARM → RUN → DRAIN → REPORT → IDLE, or REPORT → ARM.
- IDLE:
  - `start` → ARM.
  - `stop` is ignored.
- ARM (exactly 3 cycles):
  - `ana_rst_n` = 0 in cycles 1–2, 1 in cycle 3; then RUN.
  - Sample counter, accumulator, sat and peak clear on ARM entry.
  - `ana_*_th` load from the shadows on the edge entering ARM, using the pre-edge shadow value.
  - A `cfg_wr` on that same edge updates only the shadow.
- RUN:
  - `ana_valid_in` = `samp_valid` (combinational AND with state==RUN).
  - Each beat increments the sample counter.
  - On the beat making count == max(win_len,1), or on `stop`, go to DRAIN. Both in the same cycle behave identically; that beat is counted.
  - `win_len` is sampled continuously; a value at or below the current count ends the window on the next beat.
- DRAIN:
  - Exactly PIPE_LAT cycles, then REPORT.
  - `ana_valid_in` = 0.
- Accumulation (RUN and DRAIN only):
  - On `ana_valid_out`, add `ana_pulse_count` to a CNT_W accumulator.
  - Saturate at all-ones and set `res_sat` sticky.
  - `ana_valid_out` outside RUN/DRAIN is ignored.
- REPORT:
  - `res_valid` = 1; `res_*` held stable until `res_valid && res_ready`.
  - Samples arriving in REPORT/ARM/DRAIN are dropped (not forwarded).
- Handshake exit: go to ARM if `cont_mode` && no `stop` latched since the last ARM; otherwise go to IDLE.
- `stop` is latched in any non-IDLE state and cleared on ARM entry.
- `start` while busy is ignored.
- `cfg_wr` is accepted in any state; `ana_*_th` never change outside the ARM entry edge.
- A pair spanning a window boundary is discarded by the ARM clear; this is accepted behaviour.

## Timing
- Reset (`rst_n` low at edge):
  - state=IDLE; `ana_rst_n`=0, so the analyzer is held clear during reset; `ana_*_th`=0; shadows=0.
  - `res_valid`=0, `res_count`=0, `res_samples`=0, `res_sat`=0, `res_peak`=0.
  - `busy`=0; `ana_valid_in`=0.
- First IDLE cycle after reset drives `ana_rst_n`=1.
- Reset mid-window aborts with no result.
- `start` sampled at edge t: ARM in t+1..t+3, RUN from t+4.
- Last RUN beat at cycle r: DRAIN r+1..r+PIPE_LAT; `res_valid` rises at r+PIPE_LAT+1.
- Result handshake at edge h:
  - `res_valid`=0 from h+1 (non-continuous).
  - Continuous mode: ARM at h+1..h+3, RUN at h+4.

## Configuration
- PULSE_WIN_PEAK_EN defined:
  - `res_peak` holds the max `ana_pulse_count` seen with `ana_valid_out` in RUN/DRAIN.
  - Cleared on ARM entry; held through REPORT.
- Not defined: `res_peak` is tied 0 and the peak register is removed.

## Structure
- Shared package `pulse_win_pkg`:
  - state enum (IDLE, ARM, RUN, DRAIN, REPORT);
  - ARM_CYC=3;
  - default PIPE_LAT;
  - CNT_W/LEN_W defaults.
- One natural sub-module: `sat_accum`, a saturating CNT_W accumulator with sticky sat flag and clear.
- Everything else is in a single FSM module.

## Test plan
- win_len=4, PIPE_LAT=8, 4 consecutive beats, analyzer returns counts 1,2,0,3 → res_count=6, res_samples=4; res_valid 9 cycles after the last beat.
- stop on 2nd beat of win_len=10 → DRAIN immediately, res_samples=2; a `start` pulsed in RUN is ignored.
- cfg_wr with new thresholds during RUN → `ana_*_th` unchanged until the next ARM entry; cfg_wr on the ARM entry edge applies only on the following window.
- CNT_W=4, counts 8,8 → res_count=15, res_sat=1.
- cont_mode=1, res_ready held low 5 cycles → res_* stable, samples dropped; on handshake ARM follows with `ana_rst_n` low for 2 cycles; `stop` in REPORT → IDLE after the handshake.
- `rst_n` low in RUN → all outputs at reset values next cycle; with PULSE_WIN_PEAK_EN, counts 3,7,2 → res_peak=7.

Source files
------------

// File: rtl/pulse_win_pkg.sv
// Shared types and defaults for the pulse window sequencer.
// Holds the FSM state encoding and default widths/latencies.
package pulse_win_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN,
    REPORT
  } state_t;

  localparam int ARM_CYC      = 3;
  localparam int PIPE_LAT_DEF = 8;
  localparam int CNT_W_DEF    = 24;
  localparam int LEN_W_DEF    = 32;
  localparam int DATA_W_DEF   = 20;

endpackage

// File: rtl/sat_accum.sv
// Saturating accumulator with sticky saturation flag and sync clear.
// Sticks at all-ones once an add would carry out of W bits.
module sat_accum
  import pulse_win_pkg::*;
#(
  parameter int W    = CNT_W_DEF,
  parameter int IN_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [IN_W-1:0] add,
  output logic [W-1:0]    sum,
  output logic            sat
);

  localparam int EW = ((W > IN_W) ? W : IN_W) + 1;

  logic [EW-1:0] ext;
  logic          ovf;

  always_comb begin
    ext = EW'(sum) + EW'(add);
    ovf = |ext[EW-1:W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      sum <= '0;
      sat <= 1'b0;
    end else if (en) begin
      if (ovf) begin
        sum <= '1;
        sat <= 1'b1;
      end else begin
        sum <= ext[W-1:0];
      end
    end
  end

endmodule

// File: rtl/pulse_window_ctrl.sv
// Window sequencer for the zero-point pulse analyzer.
// Define PULSE_WIN_PEAK_EN to track the per-window peak pulse_count.
module pulse_window_ctrl
  import pulse_win_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  cont_mode,
  input  logic [LEN_W-1:0]      win_len,
  input  logic                  cfg_wr,
  input  logic [DATA_WIDTH-1:0] diff_th_in,
  input  logic [DATA_WIDTH-1:0] abs_th_in,
  input  logic                  samp_valid,
  output logic                  ana_valid_in,
  output logic                  ana_rst_n,
  output logic [DATA_WIDTH-1:0] ana_diff_th,
  output logic [DATA_WIDTH-1:0] ana_abs_th,
  input  logic [4:0]            ana_pulse_count,
  input  logic                  ana_valid_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CNT_W-1:0]      res_count,
  output logic [LEN_W-1:0]      res_samples,
  output logic                  res_sat,
  output logic [4:0]            res_peak,
  output logic                  busy
);

  localparam int DRN_W = $clog2(PIPE_LAT + 1);
  localparam int ARM_W = $clog2(ARM_CYC + 1);
  localparam int LW1   = LEN_W + 1;

  state_t                  state, state_d;
  logic [ARM_W-1:0]        arm_cnt, arm_cnt_d;
  logic [DRN_W-1:0]        drn_cnt;
  logic [LEN_W-1:0]        samp_cnt;
  logic                    stop_lat;
  logic [DATA_WIDTH-1:0]   diff_sh, abs_sh;
  logic                    arm_entry, last_beat, acc_en;
  logic [LW1-1:0]          cnt_nxt, wl_eff;

  always_comb begin
    wl_eff    = (win_len == '0) ? LW1'(1) : {1'b0, win_len};
    cnt_nxt   = {1'b0, samp_cnt} + LW1'(1);
    last_beat = samp_valid && (cnt_nxt >= wl_eff);
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = ARM;
      ARM:     if (arm_cnt == ARM_W'(ARM_CYC - 1)) state_d = RUN;
      RUN:     if (stop || last_beat) state_d = DRAIN;
      DRAIN:   if (drn_cnt == DRN_W'(PIPE_LAT - 1)) state_d = REPORT;
      REPORT:
        if (res_ready)
          state_d = (cont_mode && !stop_lat && !stop) ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
    arm_entry = (state_d == ARM) && (state != ARM);
    arm_cnt_d = (state == ARM) ? arm_cnt + ARM_W'(1) : '0;
  end

  // analyzer clear is low for all but the last ARM cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      arm_cnt     <= '0;
      drn_cnt     <= '0;
      samp_cnt    <= '0;
      stop_lat    <= 1'b0;
      diff_sh     <= '0;
      abs_sh      <= '0;
      ana_diff_th <= '0;
      ana_abs_th  <= '0;
      ana_rst_n   <= 1'b0;
    end else begin
      state     <= state_d;
      arm_cnt   <= arm_cnt_d;
      ana_rst_n <= !((state_d == ARM) &&
                     (arm_cnt_d < ARM_W'(ARM_CYC - 1)));
      drn_cnt   <= (state == DRAIN) ? drn_cnt + DRN_W'(1) : '0;
      if (cfg_wr) begin
        diff_sh <= diff_th_in;
        abs_sh  <= abs_th_in;
      end
      if (arm_entry) begin
        ana_diff_th <= diff_sh;
        ana_abs_th  <= abs_sh;
        samp_cnt    <= '0;
        stop_lat    <= 1'b0;
      end else begin
        if ((state == RUN) && samp_valid)
          samp_cnt <= cnt_nxt[LEN_W-1:0];
        if ((state != IDLE) && stop)
          stop_lat <= 1'b1;
      end
    end
  end

  assign acc_en = ((state == RUN) || (state == DRAIN)) && ana_valid_out;

  sat_accum #(
    .W    (CNT_W),
    .IN_W (5)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (arm_entry),
    .en    (acc_en),
    .add   (ana_pulse_count),
    .sum   (res_count),
    .sat   (res_sat)
  );

`ifdef PULSE_WIN_PEAK_EN
  logic [4:0] peak_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      peak_q <= '0;
    else if (arm_entry)
      peak_q <= '0;
    else if (acc_en && (ana_pulse_count > peak_q))
      peak_q <= ana_pulse_count;
  end

  assign res_peak = peak_q;
`else
  assign res_peak = '0;
`endif

  assign ana_valid_in = (state == RUN) && samp_valid;
  assign res_valid    = (state == REPORT);
  assign res_samples  = samp_cnt;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_pulse_window_ctrl.sv
// Bench for pulse_window_ctrl: vector table, directed corners, random windows.
`timescale 1ns/1ps
module tb_pulse_window_ctrl;

  localparam int DW   = 20;
  localparam int CW   = 4;
  localparam int LW   = 32;
  localparam int PL   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          cont_mode = 1'b0;
  logic [LW-1:0] win_len = '0;
  logic          cfg_wr = 1'b0;
  logic [DW-1:0] diff_th_in = '0;
  logic [DW-1:0] abs_th_in = '0;
  logic          samp_valid = 1'b0;
  logic          ana_valid_in;
  logic          ana_rst_n;
  logic [DW-1:0] ana_diff_th;
  logic [DW-1:0] ana_abs_th;
  logic [4:0]    ana_pulse_count = '0;
  logic          ana_valid_out = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [CW-1:0] res_count;
  logic [LW-1:0] res_samples;
  logic          res_sat;
  logic [4:0]    res_peak;
  logic          busy;

  pulse_window_ctrl #(
    .DATA_WIDTH (DW),
    .CNT_W      (CW),
    .LEN_W      (LW),
    .PIPE_LAT   (PL)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .stop            (stop),
    .cont_mode       (cont_mode),
    .win_len         (win_len),
    .cfg_wr          (cfg_wr),
    .diff_th_in      (diff_th_in),
    .abs_th_in       (abs_th_in),
    .samp_valid      (samp_valid),
    .ana_valid_in    (ana_valid_in),
    .ana_rst_n       (ana_rst_n),
    .ana_diff_th     (ana_diff_th),
    .ana_abs_th      (ana_abs_th),
    .ana_pulse_count (ana_pulse_count),
    .ana_valid_out   (ana_valid_out),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_count       (res_count),
    .res_samples     (res_samples),
    .res_sat         (res_sat),
    .res_peak        (res_peak),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int peak_en;
  logic [DW-1:0] sh_d = '0, sh_a = '0, ap_d = '0, ap_a = '0;
  int  m_sum, m_peak, m_samp;
  bit  fixed_mode = 1'b0;
  int  fixed_q[$];

  typedef struct {
    bit st; bit sv; bit vo; int pc; bit rr;
    bit e_busy; bit e_vin; bit e_arn; bit e_rv; int e_cnt; int e_smp;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_th();
    chk("diff_th", 64'(ana_diff_th), 64'(ap_d));
    chk("abs_th", 64'(ana_abs_th), 64'(ap_a));
  endtask

  // threshold model: applied copy taken from the pre-edge shadow on ARM entry
  task automatic tick(input bit arm);
    if (arm) begin
      ap_d = sh_d;
      ap_a = sh_a;
    end
    if (cfg_wr) begin
      sh_d = diff_th_in;
      sh_a = abs_th_in;
    end
    if (!rst_n) begin
      sh_d = '0; sh_a = '0; ap_d = '0; ap_a = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cfg();
    cfg_wr     = ($urandom_range(0, 3) == 0);
    diff_th_in = DW'($urandom);
    abs_th_in  = DW'($urandom);
  endtask

  task automatic drive_ana(input bit counted);
    if (fixed_mode) begin
      ana_valid_out   = counted && (fixed_q.size() > 0);
      ana_pulse_count = ana_valid_out ? 5'(fixed_q.pop_front()) : 5'd0;
    end else begin
      ana_valid_out   = 1'($urandom_range(0, 1));
      ana_pulse_count = 5'($urandom_range(0, 5));
    end
    if (counted && ana_valid_out) begin
      m_sum += int'(ana_pulse_count);
      if (int'(ana_pulse_count) > m_peak) m_peak = int'(ana_pulse_count);
    end
  endtask

  task automatic kick(input int wl, input bit force_cfg);
    start      = 1'b1;
    stop       = 1'($urandom_range(0, 1));
    samp_valid = 1'($urandom_range(0, 1));
    drive_ana(0);
    rand_cfg();
    if (force_cfg) cfg_wr = 1'b1;
    win_len = LW'(wl);
    #1;
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_vin", 64'(ana_valid_in), 64'(0));
    chk_th();
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // one window from ARM cycle 1 through the result handshake
  task automatic do_window(input int wl, input int stop_at, input int shrink_at,
                           input int p_beat, input bit cont, input int hold,
                           input bit stop_rep, output bit armed);
    int wl_eff, n, exp_cnt;
    bit done, stopped;
    m_sum = 0; m_peak = 0; m_samp = 0; stopped = 0;
    win_len = LW'(wl);
    cont_mode = cont;
    for (int i = 1; i <= 3; i++) begin
      samp_valid = 1'($urandom_range(0, 1));
      start      = 1'($urandom_range(0, 1));
      res_ready  = 1'($urandom_range(0, 1));
      stop       = 1'b0;
      drive_ana(0);
      rand_cfg();
      #1;
      chk("arm_busy", 64'(busy), 64'(1));
      chk("arm_rst", 64'(ana_rst_n), 64'(i == 3));
      chk("arm_vin", 64'(ana_valid_in), 64'(0));
      chk("arm_rv", 64'(res_valid), 64'(0));
      chk_th();
      tick(0);
    end
    done = 0; n = 0;
    while (!done) begin
      if (n == shrink_at) win_len = LW'(m_samp);
      samp_valid = ($urandom_range(1, 100) <= p_beat);
      stop       = (n == stop_at);
      start      = 1'($urandom_range(0, 1));
      drive_ana(1);
      rand_cfg();
      #1;
      chk("run_vin", 64'(ana_valid_in), 64'(samp_valid));
      chk("run_busy", 64'(busy), 64'(1));
      chk("run_arn", 64'(ana_rst_n), 64'(1));
      chk("run_rv", 64'(res_valid), 64'(0));
      chk_th();
      wl_eff = (win_len == 0) ? 1 : int'(win_len);
      if (samp_valid) m_samp++;
      if (stop) stopped = 1;
      done = stop || (samp_valid && m_samp >= wl_eff);
      tick(0);
      n++;
      if (!done && n > 300) begin
        chk("run_timeout", 64'(0), 64'(1));
        armed = 0;
        return;
      end
    end
    stop = 1'b0;
    for (int j = 0; j < PL; j++) begin
      samp_valid = 1'($urandom_range(0, 1));
      start      = 1'($urandom_range(0, 1));
      drive_ana(1);
      rand_cfg();
      #1;
      chk("drn_vin", 64'(ana_valid_in), 64'(0));
      chk("drn_busy", 64'(busy), 64'(1));
      chk("drn_rv", 64'(res_valid), 64'(0));
      chk_th();
      tick(0);
    end
    exp_cnt = (m_sum > CMAX) ? CMAX : m_sum;
    armed = cont && !stop_rep && !stopped;
    for (int k = 0; k <= hold; k++) begin
      res_ready  = (k == hold);
      stop       = stop_rep && (k == 0);
      samp_valid = 1'($urandom_range(0, 1));
      start      = 1'($urandom_range(0, 1));
      drive_ana(0);
      rand_cfg();
      #1;
      chk("rep_rv", 64'(res_valid), 64'(1));
      chk("rep_cnt", 64'(res_count), 64'(exp_cnt));
      chk("rep_smp", 64'(res_samples), 64'(m_samp));
      chk("rep_sat", 64'(res_sat), 64'(m_sum > CMAX));
      chk("rep_peak", 64'(res_peak), 64'(peak_en != 0 ? m_peak : 0));
      chk("rep_vin", 64'(ana_valid_in), 64'(0));
      chk_th();
      tick(armed && (k == hold));
    end
    stop = 1'b0; res_ready = 1'b0; start = 1'b0;
    if (!armed) begin
      #1;
      chk("post_busy", 64'(busy), 64'(0));
      chk("post_rv", 64'(res_valid), 64'(0));
      chk("post_arn", 64'(ana_rst_n), 64'(1));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_vin"}, 64'(ana_valid_in), 64'(0));
    chk({tag, "_arn"}, 64'(ana_rst_n), 64'(0));
    chk({tag, "_rv"}, 64'(res_valid), 64'(0));
    chk({tag, "_cnt"}, 64'(res_count), 64'(0));
    chk({tag, "_smp"}, 64'(res_samples), 64'(0));
    chk({tag, "_sat"}, 64'(res_sat), 64'(0));
    chk({tag, "_peak"}, 64'(res_peak), 64'(0));
    chk_th();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1);
  end

  initial begin
    bit armed;
`ifdef PULSE_WIN_PEAK_EN
    peak_en = 1;
`else
    peak_en = 0;
`endif
    // reset with busy-looking inputs
    rst_n = 1'b0; start = 1'b1; cfg_wr = 1'b1; samp_valid = 1'b1;
    diff_th_in = 20'h0abcd; abs_th_in = 20'h01234;
    tick(0);
    tick(0);
    chk_reset_vals("rst");
    rst_n = 1'b1; start = 1'b0; cfg_wr = 1'b0; samp_valid = 1'b0;
    tick(0);
    chk("rst_rel_arn", 64'(ana_rst_n), 64'(1));
    chk("rst_rel_busy", 64'(busy), 64'(0));

    // shadow load before the table window
    cfg_wr = 1'b1; diff_th_in = 20'h12345; abs_th_in = 20'h00777;
    tick(0);
    cfg_wr = 1'b0;

    // win_len=4, four beats, counts 1,2,0,3 out of the pipeline
    win_len = LW'(4);
    tv.push_back('{1, 0, 0, 0, 0, 0, 0, 1, 0, -1, -1});
    tv.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, -1, -1});
    tv.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 0, -1, -1});
    tv.push_back('{0, 0, 0, 0, 0, 1, 0, 1, 0, -1, -1});
    for (int i = 0; i < 4; i++)
      tv.push_back('{0, 1, 0, 0, 0, 1, 1, 1, 0, -1, -1});
    for (int i = 0; i < 4; i++)
      tv.push_back('{0, 0, 0, 0, 0, 1, 0, 1, 0, -1, -1});
    tv.push_back('{0, 0, 1, 1, 0, 1, 0, 1, 0, -1, -1});
    tv.push_back('{0, 0, 1, 2, 0, 1, 0, 1, 0, -1, -1});
    tv.push_back('{0, 0, 1, 0, 0, 1, 0, 1, 0, -1, -1});
    tv.push_back('{0, 0, 1, 3, 0, 1, 0, 1, 0, -1, -1});
    tv.push_back('{0, 0, 0, 0, 1, 1, 0, 1, 1, 6, 4});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, -1, -1});
    foreach (tv[i]) begin
      start = tv[i].st; samp_valid = tv[i].sv;
      ana_valid_out = tv[i].vo; ana_pulse_count = 5'(tv[i].pc);
      res_ready = tv[i].rr; stop = 1'b0; cfg_wr = 1'b0; cont_mode = 1'b0;
      #1;
      chk("tv_busy", 64'(busy), 64'(tv[i].e_busy));
      chk("tv_vin", 64'(ana_valid_in), 64'(tv[i].e_vin));
      chk("tv_arn", 64'(ana_rst_n), 64'(tv[i].e_arn));
      chk("tv_rv", 64'(res_valid), 64'(tv[i].e_rv));
      if (tv[i].e_cnt >= 0) begin
        chk("tv_cnt", 64'(res_count), 64'(tv[i].e_cnt));
        chk("tv_smp", 64'(res_samples), 64'(tv[i].e_smp));
      end
      chk_th();
      tick(tv[i].st);
    end
    start = 1'b0; res_ready = 1'b0; ana_valid_out = 1'b0;

    // stop on the second beat of a 10-sample window
    kick(10, 1);
    do_window(10, 1, -1, 100, 0, 0, 0, armed);

    // saturation: 8 + 8 in a 4-bit total
    fixed_mode = 1'b1;
    fixed_q = '{8, 8};
    kick(2, 0);
    do_window(2, -1, -1, 100, 0, 0, 0, armed);
    fixed_q = '{3, 7, 2};
    kick(3, 0);
    do_window(3, -1, -1, 100, 0, 0, 0, armed);
    fixed_q.delete();
    fixed_mode = 1'b0;

    // continuous mode: held result, re-arm, then stop in REPORT
    kick(3, 0);
    do_window(3, -1, -1, 70, 1, 5, 0, armed);
    chk("cont_rearm", 64'(armed), 64'(1));
    do_window(2, -1, -1, 70, 1, 0, 1, armed);

    // reset in the middle of RUN
    kick(20, 0);
    for (int i = 0; i < 5; i++) begin
      samp_valid = 1'b1;
      tick(0);
    end
    rst_n = 1'b0;
    tick(0);
    chk_reset_vals("midrst");
    rst_n = 1'b1; samp_valid = 1'b0;
    tick(0);
    chk("midrst_idle", 64'(busy), 64'(0));
    chk("midrst_arn", 64'(ana_rst_n), 64'(1));

    // random windows, chaining through continuous re-arm
    armed = 0;
    for (int it = 0; it < 30; it++) begin
      int wl;
      wl = $urandom_range(0, 6);
      if (!armed) kick(wl, ($urandom_range(0, 3) == 0));
      do_window(wl,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : -1,
                $urandom_range(40, 100),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 4),
                ($urandom_range(0, 4) == 0),
                armed);
    end
    if (armed) begin
      cont_mode = 1'b0;
      do_window(1, -1, -1, 100, 0, 0, 0, armed);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
